// File: rtl/mlp_pkg.sv
// mlp_pkg
// Shared constants and types for the MLP frame loader slice.
//   NUM_PIXELS : pixels per frame (28x28 image)
//   PIX_W      : incoming pixel width
//   Q_W        : quantized pixel width stored in the core's input RAM
//   ADDR_W     : input RAM address width
//   CLASS_W    : width of the predicted class index
//   loader_state_e : sequencer states of the frame loader
package mlp_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int Q_W        = 4;
  localparam int ADDR_W     = 10;
  localparam int CLASS_W    = 4;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CRST   = 3'd1,
    CGAP   = 3'd2,
    CSTART = 3'd3,
    RUN    = 3'd4,
    REPORT = 3'd5
  } loader_state_e;

endpackage

// File: rtl/pixel_quantizer.sv
// pixel_quantizer
// Combinational round-to-nearest reduction of an unsigned PIX_W pixel to Q_W
// bits, saturating at the top code.
//   pix : unsigned input pixel (PIX_W bits)
//   q   : quantized pixel (Q_W bits), q = min(2^Q_W-1, (pix + half) >> shift)
module pixel_quantizer
  import mlp_pkg::*;
(
  input  logic [PIX_W-1:0] pix,
  output logic [Q_W-1:0]   q
);

  localparam int SHIFT = PIX_W - Q_W;
  localparam logic [PIX_W:0] HALF = {{PIX_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [PIX_W:0] sum;
  logic [Q_W:0]   scaled;

  // One extra bit of headroom so rounding the top pixels up does not wrap;
  // the carry bit then forces saturation to the largest code.
  assign sum    = {1'b0, pix} + HALF;
  assign scaled = sum[PIX_W:SHIFT];
  assign q      = scaled[Q_W] ? {Q_W{1'b1}} : scaled[Q_W-1:0];

endmodule

// File: rtl/mlp_frame_loader.sv
// mlp_frame_loader
// Feeds one frame of pixels into the MLP core's input RAM, re-arms and starts
// the core, waits for its answer and hands the result downstream.
//   clk, reset        : clock, asynchronous active-low reset
//   pix_valid/ready   : pixel stream handshake; pix_data pixel, pix_last end
//   img_wen/waddr/wdata : input RAM write port (one write per accepted beat)
//   core_reset        : active-high core reset, held CORE_RST_CYC cycles
//   core_start        : one-cycle start pulse
//   core_done/class   : core completion level and predicted class
//   res_valid/ready   : result handshake; res_class, res_error payload
//   busy              : high whenever not accepting pixels
//   frame_cnt         : number of results delivered (wrapping)
module mlp_frame_loader
  import mlp_pkg::*;
#(
  parameter int CORE_RST_CYC = 2,
  parameter int TIMEOUT_CYC  = 262144
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_last,
  output logic               pix_ready,
  output logic               img_wen,
  output logic [ADDR_W-1:0]  img_waddr,
  output logic [Q_W-1:0]     img_wdata,
  output logic               core_reset,
  output logic               core_start,
  input  logic               core_done,
  input  logic [CLASS_W-1:0] core_class,
  output logic               res_valid,
  output logic [CLASS_W-1:0] res_class,
  output logic               res_error,
  input  logic               res_ready,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int RST_W = $clog2(CORE_RST_CYC) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [RST_W-1:0]  RST_LAST = RST_W'(CORE_RST_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  loader_state_e state, state_next;

  logic [ADDR_W-1:0] pix_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [Q_W-1:0]    q_pix;
  logic              accept;
  logic              beat_is_last;
  logic              frame_end_ok;
  logic              frame_end_err;
  logic              run_timeout;

  pixel_quantizer u_quant (
    .pix (pix_data),
    .q   (q_pix)
  );

  // A frame ends either cleanly (last flag exactly on the final index) or in
  // error (last flag early, or missing on the final index). Acceptance is
  // derived from the state directly so no combinational loop goes through
  // pix_ready.
  assign accept        = pix_valid && (state == LOAD);
  assign beat_is_last  = (pix_cnt == LAST_IDX);
  assign frame_end_ok  = accept && beat_is_last && pix_last;
  assign frame_end_err = accept && (beat_is_last != pix_last);

  // tmo_cnt holds the number of cycles elapsed since core_start, so hitting
  // TIMEOUT_CYC-1 in RUN puts the error result out exactly TIMEOUT_CYC
  // cycles after the start pulse.
  assign run_timeout = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control outputs. Core done takes priority over
  // the timeout when both land in the same RUN cycle.
  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    core_reset = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b0;
        if (frame_end_ok) begin
          state_next = CRST;
        end else if (frame_end_err) begin
          state_next = REPORT;
        end
      end
      CRST: begin
        core_reset = 1'b1;
        if (rst_cnt == RST_LAST) begin
          state_next = CGAP;
        end
      end
      CGAP: begin
        state_next = CSTART;
      end
      CSTART: begin
        core_start = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (core_done || run_timeout) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Datapath: RAM write pipeline, beat/reset/timeout counters, result
  // registers and the delivered-frame counter. pix_cnt is zeroed whenever
  // the loader is not loading, so every re-entry into LOAD starts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_wen   <= 1'b0;
      img_waddr <= '0;
      img_wdata <= '0;
      pix_cnt   <= '0;
      rst_cnt   <= '0;
      tmo_cnt   <= '0;
      res_class <= '0;
      res_error <= 1'b0;
      frame_cnt <= '0;
    end else begin
      img_wen <= accept;
      if (accept) begin
        img_waddr <= pix_cnt;
        img_wdata <= q_pix;
      end

      if ((state != LOAD) || frame_end_ok || frame_end_err) begin
        pix_cnt <= '0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + ADDR_W'(1);
      end

      rst_cnt <= (state == CRST) ? rst_cnt + RST_W'(1) : '0;
      tmo_cnt <= ((state == CSTART) || (state == RUN)) ? tmo_cnt + TMO_W'(1) : '0;

      if (frame_end_err) begin
        res_class <= '0;
        res_error <= 1'b1;
      end else if (state == RUN) begin
        if (core_done) begin
          res_class <= core_class;
          res_error <= 1'b0;
        end else if (run_timeout) begin
          res_class <= '0;
          res_error <= 1'b1;
        end
      end else if ((state == REPORT) && res_ready) begin
        res_class <= '0;
        res_error <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mlp_frame_loader.sv
// tb_mlp_frame_loader
// Randomized scoreboard bench for mlp_frame_loader with a behavioural core
// model. Stimulus pushes expected RAM writes and results; a negedge monitor
// pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_mlp_frame_loader;
  import mlp_pkg::*;

  localparam int RST_CYC = 2;
  localparam int TMO     = 2000;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               pix_valid = 1'b0;
  logic [PIX_W-1:0]   pix_data = '0;
  logic               pix_last = 1'b0;
  logic               pix_ready;
  logic               img_wen;
  logic [ADDR_W-1:0]  img_waddr;
  logic [Q_W-1:0]     img_wdata;
  logic               core_reset;
  logic               core_start;
  logic               core_done = 1'b0;
  logic [CLASS_W-1:0] core_class = '0;
  logic               res_valid;
  logic [CLASS_W-1:0] res_class;
  logic               res_error;
  logic               res_ready = 1'b0;
  logic               busy;
  logic [15:0]        frame_cnt;

  always #5 clk = ~clk;

  mlp_frame_loader #(
    .CORE_RST_CYC (RST_CYC),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .img_wen    (img_wen),
    .img_waddr  (img_waddr),
    .img_wdata  (img_wdata),
    .core_reset (core_reset),
    .core_start (core_start),
    .core_done  (core_done),
    .core_class (core_class),
    .res_valid  (res_valid),
    .res_class  (res_class),
    .res_error  (res_error),
    .res_ready  (res_ready),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int cls;
    int err;
    bit started;
    int lat;
  } res_t;

  wr_t wq[$];
  res_t rq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_count = 0;
  int exp_frames = 0;
  int core_delay = 0;
  int elapsed = 0;
  int last_acc = 0;
  int start_cyc = 0;
  int rst_run = 0;
  logic prev_rv = 1'b0;
  logic [CLASS_W-1:0] prev_cls = '0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc++;

  // Behavioural core: done rises core_delay cycles after start (0 = never)
  // and stays high until the next core reset.
  always @(posedge clk) begin
    if (core_reset) begin
      core_done <= 1'b0;
      elapsed   <= 0;
    end else if (core_start) begin
      elapsed   <= 1;
      core_done <= (core_delay == 1);
    end else if (elapsed > 0) begin
      elapsed <= elapsed + 1;
      if ((core_delay != 0) && (elapsed + 1 == core_delay)) core_done <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic abortRun(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  function automatic int quantRef(input int p);
    int r;
    r = (p + 8) / 16;
    return (r > 15) ? 15 : r;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_frames = 0;
      prev_rv    = 1'b0;
      rst_run    = 0;
    end else begin
      if (pix_valid && pix_ready) last_acc = cyc;

      if (img_wen) begin
        checkOutput("write_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          checkOutput("img_waddr", 32'(img_waddr), w.addr);
          checkOutput("img_wdata", 32'(img_wdata), w.data);
        end
      end

      if (core_reset) begin
        rst_run++;
        if (rst_run == 1) begin
          checkOutput("core_reset_expected", 32'(rq.size() > 0 && rq[0].started), 1);
          checkOutput("core_reset_lat", cyc - last_acc, 1);
        end
      end else if (rst_run != 0) begin
        checkOutput("core_reset_len", rst_run, RST_CYC);
        rst_run = 0;
      end

      if (core_start) begin
        checkOutput("core_start_expected", 32'(rq.size() > 0 && rq[0].started), 1);
        checkOutput("core_start_lat", cyc - last_acc, 2 + RST_CYC);
        start_cyc = cyc;
      end

      if (res_valid && !prev_rv) begin
        checkOutput("result_expected", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          if (rq[0].started) checkOutput("res_lat_from_start", cyc - start_cyc, rq[0].lat);
          else checkOutput("res_lat_from_beat", cyc - last_acc, 1);
        end
      end

      if (res_valid && prev_rv) begin
        checkOutput("res_class_stable", 32'(res_class), 32'(prev_cls));
        checkOutput("res_error_stable", 32'(res_error), 32'(prev_err));
      end

      if (res_valid && res_ready && rq.size() > 0) begin
        res_t r;
        r = rq.pop_front();
        checkOutput("res_class", 32'(res_class), r.cls);
        checkOutput("res_error", 32'(res_error), r.err);
        checkOutput("frame_cnt", 32'(frame_cnt), exp_frames);
        exp_frames++;
        hs_count++;
      end

      prev_rv  = res_valid;
      prev_cls = res_class;
      prev_err = res_error;
    end
  end

  task automatic checkReset();
    checkOutput("rst_pix_ready", 32'(pix_ready), 1);
    checkOutput("rst_img_wen", 32'(img_wen), 0);
    checkOutput("rst_img_waddr", 32'(img_waddr), 0);
    checkOutput("rst_core_reset", 32'(core_reset), 0);
    checkOutput("rst_core_start", 32'(core_start), 0);
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_res_error", 32'(res_error), 0);
    checkOutput("rst_res_class", 32'(res_class), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    checkReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame. last_at: index carrying pix_last (-1 = none);
  // delay: core cycles to done (0 = never); stall: cycles to hold res_ready
  // low in REPORT; pattern 0 = i%256 else random; reset_at >= 0 aborts the
  // frame with a reset after that many beats.
  task automatic applyStimulus(input int last_at, input int delay, input int cls,
                               input int stall, input int pattern, input int reset_at);
    int frame_len;
    bit ok;
    bit tmo_hit;
    int target;
    int n;
    res_t r;
    wr_t w;

    frame_len = (last_at >= 0 && last_at < NUM_PIXELS) ? last_at + 1 : NUM_PIXELS;
    ok = (last_at == NUM_PIXELS - 1);
    tmo_hit = (delay == 0) || (delay >= TMO);
    core_delay = delay;
    core_class = CLASS_W'(cls);

    if (reset_at < 0) begin
      r.started = ok;
      r.err = (!ok || tmo_hit) ? 1 : 0;
      r.cls = (r.err != 0) ? 0 : cls;
      r.lat = tmo_hit ? TMO : delay + 1;
      rq.push_back(r);
    end
    target = hs_count + 1;
    res_ready = 1'b0;

    for (int i = 0; i < frame_len; i++) begin
      if (reset_at >= 0 && i == reset_at) break;
      if ($urandom_range(0, 7) == 0) begin
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      pix_valid = 1'b1;
      pix_data  = (pattern == 0) ? PIX_W'(i % 256) : PIX_W'($urandom_range(0, 255));
      pix_last  = (i == last_at);
      if (stall == 0) res_ready = 1'($urandom_range(0, 1));
      n = 0;
      @(negedge clk);
      while (!pix_ready && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (!pix_ready) abortRun("pix_ready_wait");
      w.addr = i;
      w.data = quantRef(int'(pix_data));
      wq.push_back(w);
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;

    if (reset_at >= 0) begin
      repeat (2) @(posedge clk);
      #1;
      doReset();
      checkOutput("writes_drained", wq.size(), 0);
      return;
    end

    if (stall > 0) begin
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (!res_valid) abortRun("res_valid_wait");
      for (int k = 0; k < stall; k++) begin
        pix_valid = 1'($urandom_range(0, 1));
        pix_data  = PIX_W'($urandom_range(0, 255));
        pix_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("stall_pix_ready", 32'(pix_ready), 0);
        checkOutput("stall_res_valid", 32'(res_valid), 1);
        checkOutput("stall_busy", 32'(busy), 1);
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
    end

    res_ready = 1'b1;
    n = 0;
    while (hs_count < target && n < TMO + 3000) begin
      @(posedge clk);
      n++;
    end
    if (hs_count < target) abortRun("result_handshake_wait");
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("load_pix_ready", 32'(pix_ready), 1);
    checkOutput("load_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    abortRun("global_watchdog");
  end

  initial begin
    doReset();
    applyStimulus(783, 1000, 7, 0, 0, -1);
    applyStimulus(100, 50, 3, 0, 1, -1);
    applyStimulus(783, $urandom_range(1, 300), $urandom_range(0, 15), 0, 1, -1);
    applyStimulus(783, 0, 5, 0, 1, -1);
    applyStimulus(783, TMO - 1, 9, 0, 1, -1);
    applyStimulus(783, TMO, 4, 0, 1, -1);
    applyStimulus(-1, 10, 2, 0, 1, -1);
    applyStimulus(20, 10, 2, 50, 1, -1);
    applyStimulus(783, 10, 1, 0, 1, 400);
    applyStimulus(783, 500, 12, 0, 1, -1);
    for (int f = 0; f < 4; f++) begin
      int la;
      la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 782) : 783;
      applyStimulus(la, $urandom_range(1, 400), $urandom_range(0, 15), 0, 1, -1);
    end
    @(negedge clk);
    checkOutput("final_frame_cnt", 32'(frame_cnt), exp_frames);
    checkOutput("final_writes_left", wq.size(), 0);
    checkOutput("final_results_left", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
